// File: rtl/baccarat_ctrl_if.sv
// Signal bundle between the baccarat sequencing FSM and the card datapath.
// The controller takes the slave view; the datapath/bench takes the master view.
interface baccarat_ctrl_if #(parameter int CNT_W = 8);
   logic             new_hand;
   logic [3:0]       pscore;
   logic [3:0]       dscore;
   logic [3:0]       pcard3;
   logic             load_pcard1;
   logic             load_pcard2;
   logic             load_pcard3;
   logic             load_dcard1;
   logic             load_dcard2;
   logic             load_dcard3;
   logic             clear_hand;
   logic             player_win_light;
   logic             dealer_win_light;
   logic             hand_done;
   logic [CNT_W-1:0] hands_played;
   logic [CNT_W-1:0] player_wins;
   logic [CNT_W-1:0] dealer_wins;

   modport master (
      output new_hand, pscore, dscore, pcard3,
      input  load_pcard1, load_pcard2, load_pcard3,
      input  load_dcard1, load_dcard2, load_dcard3,
      input  clear_hand, player_win_light, dealer_win_light, hand_done,
      input  hands_played, player_wins, dealer_wins
   );

   modport slave (
      input  new_hand, pscore, dscore, pcard3,
      output load_pcard1, load_pcard2, load_pcard3,
      output load_dcard1, load_dcard2, load_dcard3,
      output clear_hand, player_win_light, dealer_win_light, hand_done,
      output hands_played, player_wins, dealer_wins
   );
endinterface

// File: rtl/baccarat_ctrl.sv
// Punto-banco sequencing FSM: deals six cards in order, applies third-card
// rules, lights the winner and keeps saturating hand/win tallies.
//
//   state  | meaning
//   S_P1   | load player card 1
//   S_D1   | load dealer card 1
//   S_P2   | load player card 2
//   S_D2   | load dealer card 2
//   S_CHK  | two-card scores valid: natural / player draw / player stands
//   S_P3   | load player card 3
//   S_BCHK | dealer third-card decision from dealer score and player card 3
//   S_D3   | load dealer card 3
//   S_DONE | show winner, wait for new_hand
//   S_CLR  | one-cycle clear of datapath card registers
module baccarat_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic           slow_clock,
   input  logic           resetb,
   baccarat_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      S_P1   = 4'd0,
      S_D1   = 4'd1,
      S_P2   = 4'd2,
      S_D2   = 4'd3,
      S_CHK  = 4'd4,
      S_P3   = 4'd5,
      S_BCHK = 4'd6,
      S_D3   = 4'd7,
      S_DONE = 4'd8,
      S_CLR  = 4'd9
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       v;
   logic             dealer_draws;
   logic             enter_done;
   logic [CNT_W-1:0] hands_played, player_wins, dealer_wins;
   logic             ld_p1, ld_p2, ld_p3, ld_d1, ld_d2, ld_d3;
   logic             clr, done, p_light, d_light;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == '1) ? x : x + ONE;
   endfunction

   always_ff @(posedge slow_clock) begin
      if (!resetb) state <= S_P1;
      else         state <= state_nxt;
   end

   // Face cards and tens count as zero toward the dealer's drawing table.
   assign v = (bus.pcard3 >= 4'd10) ? 4'd0 : bus.pcard3;

   always_comb begin
      dealer_draws = 1'b0;
      case (bus.dscore)
         4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
         4'd3:             dealer_draws = (v != 4'd8);
         4'd4:             dealer_draws = (v >= 4'd2) && (v <= 4'd7);
         4'd5:             dealer_draws = (v >= 4'd4) && (v <= 4'd7);
         4'd6:             dealer_draws = (v >= 4'd6) && (v <= 4'd7);
         default:          dealer_draws = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = S_P1;
      case (state)
         S_P1:   state_nxt = S_D1;
         S_D1:   state_nxt = S_P2;
         S_P2:   state_nxt = S_D2;
         S_D2:   state_nxt = S_CHK;
         S_CHK: begin
            if ((bus.pscore >= 4'd8) || (bus.dscore >= 4'd8)) state_nxt = S_DONE;
            else if (bus.pscore <= 4'd5)                       state_nxt = S_P3;
            else if (bus.dscore <= 4'd5)                       state_nxt = S_D3;
            else                                               state_nxt = S_DONE;
         end
         S_P3:   state_nxt = S_BCHK;
         S_BCHK: state_nxt = dealer_draws ? S_D3 : S_DONE;
         S_D3:   state_nxt = S_DONE;
         S_DONE: state_nxt = bus.new_hand ? S_CLR : S_DONE;
         S_CLR:  state_nxt = S_P1;
         default: state_nxt = S_P1;
      endcase
   end

   assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         hands_played <= '0;
         player_wins  <= '0;
         dealer_wins  <= '0;
      end else if (enter_done) begin
         hands_played <= sat_inc(hands_played);
         if (bus.pscore > bus.dscore) player_wins <= sat_inc(player_wins);
         if (bus.dscore > bus.pscore) dealer_wins <= sat_inc(dealer_wins);
      end
   end

   always_comb begin
      ld_p1   = 1'b0;
      ld_p2   = 1'b0;
      ld_p3   = 1'b0;
      ld_d1   = 1'b0;
      ld_d2   = 1'b0;
      ld_d3   = 1'b0;
      clr     = 1'b0;
      done    = 1'b0;
      p_light = 1'b0;
      d_light = 1'b0;
      case (state)
         S_P1:   ld_p1 = 1'b1;
         S_D1:   ld_d1 = 1'b1;
         S_P2:   ld_p2 = 1'b1;
         S_D2:   ld_d2 = 1'b1;
         S_P3:   ld_p3 = 1'b1;
         S_D3:   ld_d3 = 1'b1;
         S_CLR:  clr   = 1'b1;
         S_DONE: begin
            done    = 1'b1;
            p_light = (bus.pscore >= bus.dscore);
            d_light = (bus.dscore >= bus.pscore);
         end
         default: ;
      endcase
   end

   assign bus.load_pcard1      = ld_p1;
   assign bus.load_pcard2      = ld_p2;
   assign bus.load_pcard3      = ld_p3;
   assign bus.load_dcard1      = ld_d1;
   assign bus.load_dcard2      = ld_d2;
   assign bus.load_dcard3      = ld_d3;
   assign bus.clear_hand       = clr;
   assign bus.hand_done        = done;
   assign bus.player_win_light = p_light;
   assign bus.dealer_win_light = d_light;
   assign bus.hands_played     = hands_played;
   assign bus.player_wins      = player_wins;
   assign bus.dealer_wins      = dealer_wins;

endmodule
